// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: store FIFO ahead of DMemBank with load priority and youngest-match forwarding
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic [DW-1:0]            ld_data,
    output logic                     ld_fwd,
    input  logic                     sync,
    output logic                     sync_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     mem_memread,
    output logic                     mem_memwrite,
    output logic [AW-1:0]            mem_address,
    output logic [DW-1:0]            mem_writedata,
    input  logic [DW-1:0]            mem_readdata
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, DRAIN, STALL} state_t;
    state_t          r_state;
    logic [AW-1:0]   r_addr [DEPTH];
    logic [DW-1:0]   r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]   r_head, r_tail;
    logic [PW:0]     r_count;
    logic            w_enq, w_retire;
    logic [PW-1:0]   w_idx;
    assign count         = r_count;
    assign st_ready      = r_count != (PW+1)'(DEPTH) && !sync;
    assign sync_done     = r_count == '0;
    assign w_enq         = st_valid && st_ready;
    assign w_retire      = mem_memwrite;
    assign mem_memread   = ld_valid;
    assign mem_memwrite  = !ld_valid && r_count != '0;
    assign mem_address   = ld_valid ? ld_addr : (mem_memwrite ? r_addr[r_head] : '0);
    assign mem_writedata = mem_memwrite ? r_data[r_head] : '0;
    // Walk oldest to youngest so the last hit is the youngest matching store
    always_comb begin
        ld_fwd  = 1'b0;
        ld_data = mem_readdata;
        w_idx   = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (ld_valid && r_valid[w_idx] && r_addr[w_idx] == ld_addr) begin
                ld_fwd  = 1'b1;
                ld_data = r_data[w_idx];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_state <= IDLE;
        end else begin
            if (w_retire) r_head <= r_head + PW'(1);
            if (w_enq) r_tail <= r_tail + PW'(1);
            r_count <= r_count + (PW+1)'(w_enq) - (PW+1)'(w_retire);
            for (int i = 0; i < DEPTH; i++) begin
                if (w_enq && r_tail == PW'(i)) r_valid[i] <= 1'b1;
                else if (w_retire && r_head == PW'(i)) r_valid[i] <= 1'b0;
            end
            case (r_state)
                IDLE:    if (w_enq) r_state <= DRAIN;
                DRAIN:   if (ld_valid) r_state <= STALL;
                         else if (w_retire && r_count == (PW+1)'(1) && !w_enq) r_state <= IDLE;
                STALL:   if (!ld_valid) r_state <= DRAIN;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed scenarios against a small behavioural DMemBank (word i initialised to 10*i)
module tb_dmem_store_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid, ld_valid, sync;
    logic [31:0] st_addr, st_data, ld_addr;
    logic        st_ready, ld_fwd, sync_done;
    logic [31:0] ld_data;
    logic [2:0]  count;
    logic        mem_memread, mem_memwrite;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        tb_clr;
    logic [63:0] wr_mask;
    logic [31:0] wr_data [64];
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dmem_store_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_fwd(ld_fwd),
        .sync(sync), .sync_done(sync_done), .count(count),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    always @(posedge clk) begin
        if (tb_clr) wr_mask <= '0;
        else if (mem_memwrite) begin
            wr_mask[mem_address[5:0]] <= 1'b1;
            wr_data[mem_address[5:0]] <= mem_writedata;
        end
    end

    always_comb mem_readdata = wr_mask[mem_address[5:0]] ? wr_data[mem_address[5:0]]
                                                          : 32'(mem_address[5:0]) * 32'd10;

    function automatic logic [31:0] bank(input int a);
        return wr_mask[a] ? wr_data[a] : 32'(a * 10);
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; tb_clr = 1'b1; st_valid = 1'b0; ld_valid = 1'b0; sync = 1'b0;
        st_addr = '0; st_data = '0; ld_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        vecs++; if (st_ready !== 1'b1) begin errs++; $display("FAIL rst_st_ready got %b exp 1", st_ready); end
        vecs++; if (sync_done !== 1'b1) begin errs++; $display("FAIL rst_sync_done got %b exp 1", sync_done); end
        vecs++; if (mem_memwrite !== 1'b0) begin errs++; $display("FAIL rst_memwrite got %b exp 0", mem_memwrite); end
        vecs++; if (mem_memread !== 1'b0) begin errs++; $display("FAIL rst_memread got %b exp 0", mem_memread); end
        vecs++; if (ld_fwd !== 1'b0) begin errs++; $display("FAIL rst_ld_fwd got %b exp 0", ld_fwd); end
        vecs++; if (mem_address !== 32'd0) begin errs++; $display("FAIL rst_address got %0d exp 0", mem_address); end
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL rst_count got %0d exp 0", count); end
        rst_n = 1'b1; tb_clr = 1'b0;
    endtask

    task automatic test_drain3;
        int a[3] = '{5, 6, 7};
        int d[3] = '{11, 22, 33};
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'(a[0]); st_data = 32'(d[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) begin st_addr = 32'(a[i+1]); st_data = 32'(d[i+1]); end
            else st_valid = 1'b0;
            #1;
            vecs++; if (mem_memwrite !== 1'b1) begin errs++; $display("FAIL drain_memwrite[%0d] got %b exp 1", i, mem_memwrite); end
            vecs++; if (mem_address !== 32'(a[i])) begin errs++; $display("FAIL drain_addr[%0d] got %0d exp %0d", i, mem_address, a[i]); end
            vecs++; if (mem_writedata !== 32'(d[i])) begin errs++; $display("FAIL drain_data[%0d] got %0d exp %0d", i, mem_writedata, d[i]); end
            vecs++; if (count !== 3'd1) begin errs++; $display("FAIL drain_count[%0d] got %0d exp 1", i, count); end
        end
        @(negedge clk); #1;
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL drain_final_count got %0d exp 0", count); end
        vecs++; if (sync_done !== 1'b1) begin errs++; $display("FAIL drain_sync_done got %b exp 1", sync_done); end
        vecs++; if (mem_memwrite !== 1'b0) begin errs++; $display("FAIL drain_idle_memwrite got %b exp 0", mem_memwrite); end
        for (int i = 0; i < 3; i++) begin
            vecs++; if (bank(a[i]) !== 32'(d[i])) begin errs++; $display("FAIL drain_bank[%0d] got %0d exp %0d", a[i], bank(a[i]), d[i]); end
        end
    endtask

    task automatic test_forward;
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'd9; st_data = 32'd77;
        @(negedge clk);
        st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'd9;
        #1;
        vecs++; if (ld_fwd !== 1'b1) begin errs++; $display("FAIL fwd_hit_flag got %b exp 1", ld_fwd); end
        vecs++; if (ld_data !== 32'd77) begin errs++; $display("FAIL fwd_hit_data got %0d exp 77", ld_data); end
        vecs++; if (mem_memread !== 1'b1 || mem_memwrite !== 1'b0) begin errs++; $display("FAIL fwd_port got rd=%b wr=%b exp rd=1 wr=0", mem_memread, mem_memwrite); end
        vecs++; if (mem_address !== 32'd9) begin errs++; $display("FAIL fwd_port_addr got %0d exp 9", mem_address); end
        @(negedge clk);
        ld_addr = 32'd10;
        #1;
        vecs++; if (ld_fwd !== 1'b0) begin errs++; $display("FAIL fwd_miss_flag got %b exp 0", ld_fwd); end
        vecs++; if (ld_data !== 32'd100) begin errs++; $display("FAIL fwd_miss_data got %0d exp 100", ld_data); end
        @(negedge clk);
        ld_addr = 32'd12; st_valid = 1'b1; st_addr = 32'd12; st_data = 32'd55;
        #1;
        vecs++; if (ld_fwd !== 1'b0) begin errs++; $display("FAIL fwd_samecyc_flag got %b exp 0", ld_fwd); end
        vecs++; if (ld_data !== 32'd120) begin errs++; $display("FAIL fwd_samecyc_data got %0d exp 120", ld_data); end
        @(negedge clk);
        st_valid = 1'b0; ld_valid = 1'b0;
        #1;
        vecs++; if (count !== 3'd2) begin errs++; $display("FAIL fwd_count got %0d exp 2", count); end
        vecs++; if (mem_address !== 32'd9) begin errs++; $display("FAIL fwd_drain0_addr got %0d exp 9", mem_address); end
        @(negedge clk); #1;
        vecs++; if (mem_address !== 32'd12) begin errs++; $display("FAIL fwd_drain1_addr got %0d exp 12", mem_address); end
        @(negedge clk); #1;
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL fwd_final_count got %0d exp 0", count); end
        vecs++; if (bank(9) !== 32'd77 || bank(12) !== 32'd55) begin errs++; $display("FAIL fwd_bank got %0d,%0d exp 77,55", bank(9), bank(12)); end
    endtask

    task automatic test_youngest;
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 32'd0; st_valid = 1'b1; st_addr = 32'd4; st_data = 32'd1;
        @(negedge clk);
        st_data = 32'd2;
        @(negedge clk);
        st_valid = 1'b0; ld_addr = 32'd4;
        #1;
        vecs++; if (count !== 3'd2) begin errs++; $display("FAIL young_count got %0d exp 2", count); end
        vecs++; if (ld_fwd !== 1'b1) begin errs++; $display("FAIL young_flag got %b exp 1", ld_fwd); end
        vecs++; if (ld_data !== 32'd2) begin errs++; $display("FAIL young_data got %0d exp 2", ld_data); end
        @(negedge clk);
        ld_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL young_final_count got %0d exp 0", count); end
        vecs++; if (bank(4) !== 32'd2) begin errs++; $display("FAIL young_bank got %0d exp 2", bank(4)); end
    endtask

    task automatic test_full;
        int ea[5] = '{20, 21, 22, 23, 24};
        int ed[5] = '{160, 161, 162, 163, 99};
        int ec[5] = '{4, 3, 3, 2, 1};
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 32'd1; st_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st_addr = 32'(20 + i); st_data = 32'(160 + i);
            @(negedge clk);
        end
        st_addr = 32'd24; st_data = 32'd99;
        #1;
        vecs++; if (count !== 3'd4) begin errs++; $display("FAIL full_count got %0d exp 4", count); end
        vecs++; if (st_ready !== 1'b0) begin errs++; $display("FAIL full_st_ready got %b exp 0", st_ready); end
        vecs++; if (ld_fwd !== 1'b0 || ld_data !== 32'd10) begin errs++; $display("FAIL full_load got fwd=%b data=%0d exp fwd=0 data=10", ld_fwd, ld_data); end
        @(negedge clk); #1;
        vecs++; if (count !== 3'd4) begin errs++; $display("FAIL full_refused_count got %0d exp 4", count); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) ld_valid = 1'b0;
            if (i == 2) st_valid = 1'b0;
            #1;
            vecs++; if (mem_address !== 32'(ea[i]) || mem_writedata !== 32'(ed[i])) begin errs++; $display("FAIL full_drain[%0d] got a=%0d d=%0d exp a=%0d d=%0d", i, mem_address, mem_writedata, ea[i], ed[i]); end
            vecs++; if (count !== 3'(ec[i])) begin errs++; $display("FAIL full_drain_count[%0d] got %0d exp %0d", i, count, ec[i]); end
            vecs++; if (st_ready !== (i != 0)) begin errs++; $display("FAIL full_drain_ready[%0d] got %b exp %b", i, st_ready, i != 0); end
        end
        @(negedge clk); #1;
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL full_final_count got %0d exp 0", count); end
        vecs++; if (bank(22) !== 32'd162 || bank(24) !== 32'd99) begin errs++; $display("FAIL full_bank got %0d,%0d exp 162,99", bank(22), bank(24)); end
    endtask

    task automatic test_sync;
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 32'd1; st_valid = 1'b1; st_addr = 32'd30; st_data = 32'd301;
        @(negedge clk);
        st_addr = 32'd31; st_data = 32'd311;
        @(negedge clk);
        ld_valid = 1'b0; sync = 1'b1; st_addr = 32'd32; st_data = 32'd999;
        #1;
        vecs++; if (st_ready !== 1'b0 || sync_done !== 1'b0) begin errs++; $display("FAIL sync0 got ready=%b done=%b exp 0,0", st_ready, sync_done); end
        vecs++; if (count !== 3'd2 || mem_address !== 32'd30) begin errs++; $display("FAIL sync0_state got cnt=%0d a=%0d exp 2,30", count, mem_address); end
        @(negedge clk); #1;
        vecs++; if (count !== 3'd1 || sync_done !== 1'b0 || st_ready !== 1'b0) begin errs++; $display("FAIL sync1 got cnt=%0d done=%b ready=%b exp 1,0,0", count, sync_done, st_ready); end
        @(negedge clk); #1;
        vecs++; if (count !== 3'd0 || sync_done !== 1'b1 || st_ready !== 1'b0) begin errs++; $display("FAIL sync2 got cnt=%0d done=%b ready=%b exp 0,1,0", count, sync_done, st_ready); end
        st_valid = 1'b0; sync = 1'b0;
        vecs++; if (bank(30) !== 32'd301 || bank(31) !== 32'd311 || bank(32) !== 32'd320) begin errs++; $display("FAIL sync_bank got %0d,%0d,%0d exp 301,311,320", bank(30), bank(31), bank(32)); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 32'd1; st_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st_addr = 32'(40 + i); st_data = 32'(i + 1);
            @(negedge clk);
        end
        st_valid = 1'b0; ld_valid = 1'b0;
        #1;
        vecs++; if (count !== 3'd3 || mem_memwrite !== 1'b1 || mem_address !== 32'd40) begin errs++; $display("FAIL rmid_pre got cnt=%0d wr=%b a=%0d exp 3,1,40", count, mem_memwrite, mem_address); end
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (mem_memwrite !== 1'b0 || count !== 3'd0 || sync_done !== 1'b1) begin errs++; $display("FAIL rmid_async got wr=%b cnt=%0d done=%b exp 0,0,1", mem_memwrite, count, sync_done); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vecs++; if (count !== 3'd0 || mem_memwrite !== 1'b0) begin errs++; $display("FAIL rmid_after got cnt=%0d wr=%b exp 0,0", count, mem_memwrite); end
        vecs++; if (bank(40) !== 32'd400 || bank(41) !== 32'd410 || bank(42) !== 32'd420) begin errs++; $display("FAIL rmid_bank got %0d,%0d,%0d exp 400,410,420", bank(40), bank(41), bank(42)); end
    endtask

    initial begin
        test_reset();
        test_drain3();
        test_forward();
        test_youngest();
        test_full();
        test_sync();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
